// File: rtl/alu_pkg.sv
// Shared ALU definitions: op and state encodings, plus the bit positions of N/Z/C/V
// in the flags word so that the condition-check block can use the same indices.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_ORR = 3'b011,
        OP_EOR = 3'b100,
        OP_MUL = 3'b101
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        MUL_RUN = 2'b01,
        DONE    = 2'b10
    } alu_state_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Reserved encodings 110/111 fall back to ADD.
    function automatic alu_op_e decode_op(input logic [2:0] code);
        case (code)
            3'b001:  return OP_SUB;
            3'b010:  return OP_AND;
            3'b011:  return OP_ORR;
            3'b100:  return OP_EOR;
            3'b101:  return OP_MUL;
            default: return OP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mul_iter.sv
// Shift-add multiplier, one multiplier bit per cycle LSB first; keeps the low WIDTH bits.
// product already includes the partial product of the current step, so it is final when last=1.
module mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             busy,
    output logic             last,
    output logic [WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [CW-1:0]    count;

    assign product = acc + (b_sh[0] ? a_sh : '0);
    assign last    = (count == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            a_sh  <= '0;
            b_sh  <= '0;
            count <= '0;
        end else if (load) begin
            acc   <= '0;
            a_sh  <= a;
            b_sh  <= b;
            count <= '0;
        end else if (busy) begin
            acc   <= product;
            a_sh  <= a_sh << 1;
            b_sh  <= b_sh >> 1;
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/alu_flag_unit.sv
// Execute-stage ALU with NZCV generation and the architectural flags register.
// Single-cycle ops complete from the live inputs at accept; MUL runs from the latched copies.
module alu_flag_unit
    import alu_pkg::*;
#(
    parameter int         WIDTH    = 32,
    parameter logic [3:0] FLAG_RST = 4'h0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [1:0]       flag_write,
    input  logic             cond_ex,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       alu_flags,
    output logic [3:0]       flags
);
    localparam int MSB = WIDTH - 1;

    alu_state_e       state, state_next;
    alu_op_e          op_q, op_eff;
    logic [WIDTH-1:0] a_q, b_q, a_eff, b_eff;
    logic [1:0]       fw_q, fw_eff;
    logic             ce_q, ce_eff;
    logic             in_idle, accept, commit;
    logic             mul_last;
    logic [WIDTH-1:0] mul_product;
    logic [WIDTH:0]   sum_ext, diff_ext;
    logic [WIDTH-1:0] res_next;
    logic             c_next, v_next;
    logic [3:0]       alu_flags_next;

    assign in_idle = (state == IDLE);
    assign accept  = in_idle && start;
    assign busy    = !in_idle;
    assign done    = (state == DONE);
    assign commit  = (state_next == DONE) && (state != DONE);

    assign op_eff = in_idle ? decode_op(alu_control) : op_q;
    assign a_eff  = in_idle ? src_a      : a_q;
    assign b_eff  = in_idle ? src_b      : b_q;
    assign fw_eff = in_idle ? flag_write : fw_q;
    assign ce_eff = in_idle ? cond_ex    : ce_q;

    mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (accept),
        .a       (src_a),
        .b       (src_b),
        .busy    (state == MUL_RUN),
        .last    (mul_last),
        .product (mul_product)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (op_eff == OP_MUL) ? MUL_RUN : DONE;
            MUL_RUN: if (mul_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        sum_ext  = {1'b0, a_eff} + {1'b0, b_eff};
        diff_ext = {1'b0, a_eff} + {1'b0, ~b_eff} + {{WIDTH{1'b0}}, 1'b1};
        res_next = sum_ext[MSB:0];
        c_next   = sum_ext[WIDTH];
        v_next   = (a_eff[MSB] == b_eff[MSB]) && (sum_ext[MSB] != a_eff[MSB]);
        case (op_eff)
            OP_SUB: begin
                res_next = diff_ext[MSB:0];
                c_next   = diff_ext[WIDTH];
                v_next   = (a_eff[MSB] != b_eff[MSB]) && (diff_ext[MSB] != a_eff[MSB]);
            end
            OP_AND: begin res_next = a_eff & b_eff; c_next = 1'b0; v_next = 1'b0; end
            OP_ORR: begin res_next = a_eff | b_eff; c_next = 1'b0; v_next = 1'b0; end
            OP_EOR: begin res_next = a_eff ^ b_eff; c_next = 1'b0; v_next = 1'b0; end
            OP_MUL: begin res_next = mul_product;   c_next = 1'b0; v_next = 1'b0; end
            default: ;
        endcase
        alu_flags_next         = '0;
        alu_flags_next[FLAG_N] = res_next[MSB];
        alu_flags_next[FLAG_Z] = (res_next == '0);
        alu_flags_next[FLAG_C] = c_next;
        alu_flags_next[FLAG_V] = v_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            op_q  <= OP_ADD;
            a_q   <= '0;
            b_q   <= '0;
            fw_q  <= '0;
            ce_q  <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                op_q <= decode_op(alu_control);
                a_q  <= src_a;
                b_q  <= src_b;
                fw_q <= flag_write;
                ce_q <= cond_ex;
            end
        end
    end

    // result/alu_flags always update on completion; the flags register only when qualified.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result    <= '0;
            alu_flags <= '0;
            flags     <= FLAG_RST;
        end else if (commit) begin
            result    <= res_next;
            alu_flags <= alu_flags_next;
            if (fw_eff[1] && ce_eff) begin
                flags[FLAG_N] <= alu_flags_next[FLAG_N];
                flags[FLAG_Z] <= alu_flags_next[FLAG_Z];
            end
            if (fw_eff[0] && ce_eff) begin
                flags[FLAG_C] <= alu_flags_next[FLAG_C];
                flags[FLAG_V] <= alu_flags_next[FLAG_V];
            end
        end
    end

endmodule
